fpu_seq_arith: RTL and testbench

//  Multi-cycle IEEE-754-style floating-point add/sub/mul unit with valid/ready

---
 rtl/fpu_seq_arith.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_fpu_seq_arith.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fpu_seq_arith.sv
// fpu_seq_arith: multi-cycle floating-point add/sub/mul with valid/ready
// handshakes on both sides. Round-to-nearest-even, DAZ on inputs, FTZ on
// outputs, IEEE special values and per-op exception flags.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only while idle)
//   op                  00 add, 01 sub (a-b), 10 mul, 11 reserved (qNaN)
//   a_i, b_i            operands, {sign, exp[EXP_W], man[MAN_W]}
//   out_valid/out_ready result handshake; y_o/flags_o held until accepted
//   y_o                 result
//   flags_o             {invalid, overflow, underflow, inexact}
module fpu_seq_arith #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 op,
   input  logic [EXP_W+MAN_W:0]       a_i,
   input  logic [EXP_W+MAN_W:0]       b_i,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [EXP_W+MAN_W:0]       y_o,
   output logic [3:0]                 flags_o
);

   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned MW = MAN_W + 4;      // {hidden, man, g, r, s}
   localparam int unsigned SW = MAN_W + 5;      // MW plus carry bit
   localparam int unsigned EW = EXP_W + 2;      // signed working exponent
   localparam int unsigned PW = 2 * MAN_W + 2;  // full product width

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_UNPACK = 3'd1;
   localparam logic [2:0] S_ALIGN  = 3'd2;
   localparam logic [2:0] S_CALC   = 3'd3;
   localparam logic [2:0] S_NORM   = 3'd4;
   localparam logic [2:0] S_ROUND  = 3'd5;
   localparam logic [2:0] S_OUT    = 3'd6;

   localparam logic [W-1:0]        QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EXP_W-1:0]    SH_MAX = EXP_W'(MW);
   localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
   localparam logic signed [EW-1:0] ZERO_S = '0;

   logic [2:0]              state_q, state_d;
   logic [1:0]              op_q, op_d;
   logic [W-1:0]            a_q, a_d, b_q, b_d;
   logic                    sign_q, sign_d;
   logic                    eff_sub_q, eff_sub_d;
   logic                    is_mul_q, is_mul_d;
   logic signed [EW-1:0]    exp_q, exp_d;
   logic [MW-1:0]           ma_q, ma_d, mb_q, mb_d;
   logic [EXP_W-1:0]        diff_q, diff_d;
   logic [SW-1:0]           mag_q, mag_d;
   logic [W-1:0]            y_q, y_d;
   logic [3:0]              flags_q, flags_d;
   logic                    out_valid_q, out_valid_d;
   logic                    in_ready_q, in_ready_d;

   // Field decode of the latched operands
   logic                    sa, sb, sbe;
   logic [EXP_W-1:0]        ea, eb;
   logic [MAN_W-1:0]        fa, fb;
   logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;

   assign sa     = a_q[W-1];
   assign sb     = b_q[W-1];
   assign sbe    = b_q[W-1] ^ (op_q == 2'b01);
   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) && (fa == '0);
   assign b_inf  = (&eb) && (fb == '0);
   assign a_nan  = (&ea) && (fa != '0);
   assign b_nan  = (&eb) && (fb != '0);
   assign swap   = (b_q[W-2:0] > a_q[W-2:0]);

   // Special-value results, resolved entirely in UNPACK
   logic                    spec_hit;
   logic [W-1:0]            spec_y;
   logic [3:0]              spec_flags;

   always_comb begin
      spec_hit   = 1'b0;
      spec_y     = '0;
      spec_flags = '0;
      if (op_q == 2'b11 || a_nan || b_nan) begin
         spec_hit = 1'b1; spec_y = QNAN; spec_flags = 4'b1000;
      end else if (op_q == 2'b10) begin
         if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            spec_hit = 1'b1; spec_y = QNAN; spec_flags = 4'b1000;
         end else if (a_inf || b_inf) begin
            spec_hit = 1'b1; spec_y = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else if (a_zero || b_zero) begin
            spec_hit = 1'b1; spec_y = {sa ^ sb, {(W-1){1'b0}}};
         end
      end else begin
         if (a_inf && b_inf) begin
            spec_hit = 1'b1;
            if (sa != sbe) begin
               spec_y = QNAN; spec_flags = 4'b1000;
            end else begin
               spec_y = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
         end else if (a_inf) begin
            spec_hit = 1'b1; spec_y = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else if (b_inf) begin
            spec_hit = 1'b1; spec_y = {sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else if (a_zero && b_zero) begin
            // -0 only when both effective operands are negative zero
            spec_hit = 1'b1; spec_y = {sa & sbe, {(W-1){1'b0}}};
         end else if (a_zero) begin
            spec_hit = 1'b1; spec_y = {sbe, eb, fb};
         end else if (b_zero) begin
            spec_hit = 1'b1; spec_y = a_q;
         end
      end
   end

   // Aligner: right shift of the smaller mantissa, shifted-out bits into sticky
   logic [EXP_W-1:0]        sh;
   logic [2*MW-1:0]         wide;
   logic [MW-1:0]           mb_al;

   assign sh    = (diff_q >= SH_MAX) ? SH_MAX : diff_q;
   assign wide  = {mb_q, {MW{1'b0}}} >> sh;
   assign mb_al = wide[2*MW-1:MW] | MW'(|wide[MW-1:0]);

   // Arithmetic core; product bits below R fold into sticky
   logic [PW-1:0]           prod;
   logic [SW-1:0]           mag_mul, mag_add;

   assign prod    = PW'(ma_q[MW-1:3]) * PW'(mb_q[MW-1:3]);
   assign mag_mul = {prod[PW-1:MAN_W-2], |prod[MAN_W-3:0]};
   assign mag_add = eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                              : ({1'b0, ma_q} + {1'b0, mb_q});

   // Round-to-nearest-even on the normalised magnitude
   logic                    rg, rr, rs, rnd_up, inexact, mag_zero;
   logic [MAN_W:0]          mant;
   logic [MAN_W+1:0]        mant_r;
   logic [MAN_W-1:0]        frac_r;
   logic signed [EW-1:0]    exp_r;

   assign rg       = mag_q[2];
   assign rr       = mag_q[1];
   assign rs       = mag_q[0];
   assign mant     = mag_q[SW-2:3];
   assign rnd_up   = rg & (rr | rs | mant[0]);
   assign mant_r   = {1'b0, mant} + (MAN_W+2)'(rnd_up);
   assign frac_r   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
   assign exp_r    = exp_q + $signed(EW'(mant_r[MAN_W+1]));
   assign inexact  = rg | rr | rs;
   assign mag_zero = (mag_q == '0);

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      is_mul_d  = is_mul_q;
      exp_d     = exp_q;
      ma_d      = ma_q;
      mb_d      = mb_q;
      diff_d    = diff_q;
      mag_d     = mag_q;
      y_d       = y_q;
      flags_d   = flags_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d    = op;
               a_d     = a_i;
               b_d     = b_i;
               state_d = S_UNPACK;
            end
         end
         S_UNPACK: begin
            is_mul_d  = (op_q == 2'b10);
            eff_sub_d = sa ^ sbe;
            if (swap) begin
               ma_d   = {1'b1, fb, 3'b000};
               mb_d   = {1'b1, fa, 3'b000};
               diff_d = eb - ea;
               sign_d = sbe;
               exp_d  = $signed({2'b00, eb});
            end else begin
               ma_d   = {1'b1, fa, 3'b000};
               mb_d   = {1'b1, fb, 3'b000};
               diff_d = ea - eb;
               sign_d = sa;
               exp_d  = $signed({2'b00, ea});
            end
            if (op_q == 2'b10) begin
               sign_d = sa ^ sb;
               exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
            end
            if (spec_hit) begin
               y_d     = spec_y;
               flags_d = spec_flags;
               state_d = S_OUT;
            end else begin
               state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            if (!is_mul_q) mb_d = mb_al;
            state_d = S_CALC;
         end
         S_CALC: begin
            mag_d   = is_mul_q ? mag_mul : mag_add;
            state_d = S_NORM;
         end
         S_NORM: begin
            if (mag_q[SW-1]) begin
               mag_d   = {1'b0, mag_q[SW-1:2], mag_q[1] | mag_q[0]};
               exp_d   = exp_q + EW'(1);
               state_d = S_ROUND;
            end else if (mag_zero || mag_q[SW-2]) begin
               state_d = S_ROUND;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - EW'(1);
            end
         end
         S_ROUND: begin
            state_d = S_OUT;
            if (mag_zero) begin
               // exact cancellation yields +0
               y_d     = '0;
               flags_d = '0;
            end else if (exp_r >= EMAX_S) begin
               y_d     = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               flags_d = 4'b0101;
            end else if (exp_r <= ZERO_S) begin
               y_d     = {sign_q, {(W-1){1'b0}}};
               flags_d = 4'b0011;
            end else begin
               y_d     = {sign_q, exp_r[EXP_W-1:0], frac_r};
               flags_d = {3'b000, inexact};
            end
         end
         S_OUT: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_OUT);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         eff_sub_q   <= 1'b0;
         is_mul_q    <= 1'b0;
         exp_q       <= '0;
         ma_q        <= '0;
         mb_q        <= '0;
         diff_q      <= '0;
         mag_q       <= '0;
         y_q         <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sign_q      <= sign_d;
         eff_sub_q   <= eff_sub_d;
         is_mul_q    <= is_mul_d;
         exp_q       <= exp_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         diff_q      <= diff_d;
         mag_q       <= mag_d;
         y_q         <= y_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y_o       = y_q;
   assign flags_o   = flags_q;

endmodule

// File: tb/tb_fpu_seq_arith.sv
// tb_fpu_seq_arith: directed vectors for fpu_seq_arith (binary32 format)
// with hand-computed results, flags and accept-to-valid latency, plus
// backpressure and mid-operation reset.
module tb_fpu_seq_arith;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] y_o;
   logic [3:0]  flags_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fpu_seq_arith #(.EXP_W(8), .MAN_W(23)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a_i       (a_i),
      .b_i       (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_o       (y_o),
      .flags_o   (flags_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op; latency counts clock edges from the accept edge (=1)
   // to the edge after which out_valid is seen. Bounded at 100 edges.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y, output logic [3:0] f, output int lat);
      in_valid = 1'b1;
      op       = o;
      a_i      = a;
      b_i      = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      y = y_o;
      f = flags_o;
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_y,
                         input logic [3:0] exp_f, input int exp_lat);
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;
      check({tag, "_rdy"}, 32'(in_ready), 32'd1);
      run_op(o, a, b, y, f, lat);
      check({tag, "_y"}, y, exp_y);
      check({tag, "_flags"}, 32'(f), 32'(exp_f));
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   initial begin
      logic [31:0] y;
      logic [3:0]  f;
      int          lat;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 2'b00;
      a_i       = '0;
      b_i       = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_y", y_o, 32'h0);
      check("reset_flags", 32'(flags_o), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      do_vec("add_1p2",    2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 6);
      do_vec("mul_sign",   2'b10, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 4'b0000, 6);
      do_vec("sub_cancel", 2'b01, 32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 4'b0000, 30);
      do_vec("mul_ovf",    2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 6);
      do_vec("inf_m_inf",  2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 2);
      do_vec("rne_tie",    2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'b0001, 6);
      do_vec("rne_up",     2'b00, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001, 6);
      do_vec("add_carry",  2'b00, 32'h3FC00000, 32'h3FC00000, 32'h40400000, 4'b0000, 6);
      do_vec("sub_neg",    2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 7);
      do_vec("x_minus_x",  2'b01, 32'hC0490FDB, 32'hC0490FDB, 32'h00000000, 4'b0000, 6);
      do_vec("op_resv",    2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
      do_vec("nan_in",     2'b10, 32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2);
      do_vec("inf_x_0",    2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 2);
      do_vec("inf_add",    2'b01, 32'h40000000, 32'h7F800000, 32'hFF800000, 4'b0000, 2);
      do_vec("mzero_mul",  2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 2);
      do_vec("daz_add",    2'b00, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000, 2);
      do_vec("mul_ftz",    2'b10, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 6);

      // Backpressure: result held while out_ready is low; busy input ignored
      out_ready = 1'b0;
      run_op(2'b00, 32'h3F800000, 32'h40000000, y, f, lat);
      check("bp_y", y, 32'h40400000);
      check("bp_lat", 32'(lat), 32'd6);
      in_valid = 1'b1;
      op       = 2'b10;
      a_i      = 32'h40000000;
      b_i      = 32'h40000000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_y", y_o, 32'h40400000);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);

      // Reset while the normaliser is shifting
      in_valid = 1'b1;
      op       = 2'b01;
      a_i      = 32'h3F800000;
      b_i      = 32'h3F7FFFFF;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("norm_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_y", y_o, 32'h0);
      check("rst_flags", 32'(flags_o), 32'h0);

      do_vec("after_rst",  2'b10, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
